alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and in-flight tracker for the shared registered ALU (input register → ALU → output register). Each requester presents an operand pair and opcode with a valid/ready handshake. The block grants at most one request per cycle and drives the ALU inputs. It tags each issued operation and, after the ALU's fixed pipeline latency, returns the result and flags with the owner's ID.

## Interface
- N, 4, operand/result width
- LAT, 2, cycles from the issue edge to the ALU result being valid at the ALU outputs; legal range 1..8

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 granted this cycle
- req0_a, req0_b  in  N  requester 0 operands
- req0_op  in  3  requester 0 ALU opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- alu_a, alu_b  out  N  operands to the ALU input register
- alu_op  out  3  opcode to the ALU input register
- alu_issue  out  1  an operation is presented to the ALU this cycle
- alu_result  in  N  ALU output-register result
- alu_flags  in  4  ALU output-register flags {neg, zero, carry, over}
- resp_valid  out  1  response present this cycle
- resp_id  out  1  owner of the response (0/1)
- resp_result  out  N  equals alu_result when resp_valid is high
- resp_flags  out  4  equals alu_flags when resp_valid is high

## Operation
- Handshake: a transfer occurs when reqX_valid && reqX_ready at a rising edge.
  - reqX_ready is combinational from reqX_valid and the internal pointer.
  - A requester must hold valid and its payload stable until ready.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester not granted most recently.
  - Neither valid: no grant.
  - At most one ready is high per cycle.
- last_grant register updates on every transfer to the granted ID.
- On a grant, the granted payload drives alu_a/alu_b/alu_op combinationally and alu_issue = 1.
- On no grant, alu_a/alu_b/alu_op are all zero and alu_issue = 0.
- Tracker: a LAT-deep shift register of {valid, id}.
  - Stage 0 loads {alu_issue, granted id} each edge.
  - resp_valid/resp_id come from the last stage.
- Responses cannot be stalled; requesters must accept resp_valid whenever it is asserted.
- Result/flag data pass through combinationally.
- When resp_valid = 0, resp_result and resp_flags are driven to zero.
- No ordering other than issue order; responses return in exactly issue order.

## Timing
- Reset values:
  - req0_ready, req1_ready, alu_issue, resp_valid, resp_id = 0; all data outputs = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Tracker cleared.
- Throughput: one issue per cycle; back-to-back grants allowed.
- Latency: a transfer at edge k gives resp_valid high in the cycle after edge k+LAT-1, i.e. LAT cycles after issue.
- Simultaneous valid on consecutive cycles alternates strictly: 0,1,0,1…
- Reset asserted mid-operation:
  - All in-flight operations are dropped.
  - resp_valid falls immediately (asynchronously) and stays low until LAT cycles after the first post-reset issue.
- Requester dropping valid without ready is a protocol violation; the block does not check for it.

## Configuration
- ALU_ARB_STATS_EN defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (8 bits each).
  - Each counts transfers for its requester, saturating at 255.
  - Both clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
Bench model: LAT=2; ALU op 3'b000 is addition.
- Reset release, no valids:
  - All outputs 0.
  - resp_valid stays 0 for 10 cycles.
- req0 only, a=3, b=4, op=000:
  - req0_ready=1 in the same cycle.
  - 2 cycles later: resp_valid=1, resp_id=0, resp_result=7, flags zero=0.
- Both valid continuously for 4 cycles:
  - Grants in order 0,1,0,1.
  - Responses return with ids 0,1,0,1 on 4 consecutive cycles starting 2 cycles after the first grant.
- req1 alone, a=8, b=8, op=000 (N=4):
  - resp_id=1, resp_result=0, zero=1, carry=1.
- Issue 2 operations back-to-back, then assert reset one cycle after the second issue:
  - resp_valid drops at once.
  - No response for either operation after release.
- With ALU_ARB_STATS_EN: 300 requester-0-only transfers.
  - grant_cnt0=255, grant_cnt1=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of the shared-ALU arbiter.
// Latency: none (signal bundle only).
// Backpressure: valid/ready per requester; responses cannot be stalled.
interface alu_arbiter_if #(
  parameter int N = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [2:0]   req0_op;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic [2:0]   req1_op;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_op;
  logic         alu_issue;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         resp_valid;
  logic         resp_id;
  logic [N-1:0] resp_result;
  logic [3:0]   resp_flags;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, alu_flags,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op, alu_issue,
    output resp_valid, resp_id, resp_result, resp_flags
  );

  // Requesters plus ALU side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, alu_flags,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op, alu_issue,
    input  resp_valid, resp_id, resp_result, resp_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter and in-flight tracker for a shared registered ALU.
// Latency: grant/issue combinational; response LAT cycles after issue, in issue order.
// Backpressure: ready only to the granted requester; responses are never stalled.
// Optional: define ALU_ARB_STATS_EN to add saturating 8-bit grant counters.
module alu_arbiter #(
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]  grant_cnt0,
  output logic [7:0]  grant_cnt1
`endif
);

  logic           last_grant;
  logic           grant_any;
  logic           grant_id;
  logic [LAT-1:0] trk_vld;
  logic [LAT-1:0] trk_id;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = ~bus.req0_valid;
    end
  end

  assign bus.req0_ready = grant_any & ~grant_id;
  assign bus.req1_ready = grant_any & grant_id;

  // Route the granted payload to the ALU; zeros when nothing is issued.
  always_comb begin
    bus.alu_issue = grant_any;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_op    = '0;
    if (grant_any) begin
      bus.alu_a  = grant_id ? bus.req1_a  : bus.req0_a;
      bus.alu_b  = grant_id ? bus.req1_b  : bus.req0_b;
      bus.alu_op = grant_id ? bus.req1_op : bus.req0_op;
    end
  end

  // Remember the last winner; reset value 1 lets requester 0 take the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant_any) begin
      last_grant <= grant_id;
    end
  end

  // Shift {valid, id} alongside the ALU pipeline so the tag lines up with its result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_vld <= '0;
      trk_id  <= '0;
    end else begin
      trk_vld[0] <= grant_any;
      trk_id[0]  <= grant_any & grant_id;
      for (int i = 1; i < LAT; i++) begin
        trk_vld[i] <= trk_vld[i-1];
        trk_id[i]  <= trk_id[i-1];
      end
    end
  end

  assign bus.resp_valid  = trk_vld[LAT-1];
  assign bus.resp_id     = trk_id[LAT-1];
  assign bus.resp_result = bus.resp_valid ? bus.alu_result : '0;
  assign bus.resp_flags  = bus.resp_valid ? bus.alu_flags  : '0;

`ifdef ALU_ARB_STATS_EN
  // Per-requester transfer counters that stick at 255 instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (bus.req0_ready && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (bus.req1_ready && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with LAT=2 and a two-register adder ALU.
// Latency: responses checked LAT cycles after each grant.
// Backpressure: requesters hold valid until ready; responses always accepted.
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_arbiter_if #(.N(4)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0;
  logic [7:0] grant_cnt1;
`endif

  alu_arbiter #(.N(4), .LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered ALU: input register on the issue edge, output register one edge later.
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_op;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] sum;
    logic [3:0] res;
    logic [3:0] flg;
    sum = {1'b0, a} + {1'b0, b};
    res = sum[3:0];
    flg = {res[3], (res == 4'd0), sum[4], (a[3] == b[3]) && (res[3] != a[3])};
    if (op != 3'b000) return 8'h00;
    return {flg, res};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      in_a <= '0;
      in_b <= '0;
      in_op <= '0;
      bus.alu_result <= '0;
      bus.alu_flags <= '0;
    end else begin
      in_a <= bus.alu_a;
      in_b <= bus.alu_b;
      in_op <= bus.alu_op;
      {bus.alu_flags, bus.alu_result} <= alu_f(in_a, in_b, in_op);
    end
  end

  task automatic drive_idle();
    bus.req0_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req0_op = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a = '0;
    bus.req1_b = '0;
    bus.req1_op = '0;
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    reset = 1'b1;
    drive_idle();
    #3;
    outs = {bus.req0_ready, bus.req1_ready, bus.alu_issue, bus.resp_valid, bus.resp_id,
            bus.alu_a, bus.alu_b, bus.alu_op, bus.resp_result, bus.resp_flags};
    checks++;
    if (outs !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", outs, 24'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.alu_issue !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d got resp_valid=%b issue=%b exp 0 0", i, bus.resp_valid, bus.alu_issue);
      end
    end
  endtask

  task automatic test_round_robin();
    logic       exp_r0;
    logic [3:0] exp_res;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_op = 3'b000;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd3; bus.req1_b = 4'd3; bus.req1_op = 3'b000;
      end else begin
        drive_idle();
      end
      #1;
      if (i < 4) begin
        exp_r0 = (i % 2 == 0);
        checks++;
        if (bus.req0_ready !== exp_r0 || bus.req1_ready !== ~exp_r0) begin
          errors++;
          $display("FAIL rr_grant %0d got r0=%b r1=%b exp r0=%b r1=%b", i, bus.req0_ready, bus.req1_ready, exp_r0, ~exp_r0);
        end
        checks++;
        if (bus.alu_a !== (exp_r0 ? 4'd1 : 4'd3) || bus.alu_issue !== 1'b1) begin
          errors++;
          $display("FAIL rr_alu_a %0d got a=%0d issue=%b exp a=%0d issue=1", i, bus.alu_a, bus.alu_issue, exp_r0 ? 1 : 3);
        end
      end
      if (i >= 2) begin
        exp_r0 = ((i - 2) % 2 == 0);
        exp_res = exp_r0 ? 4'd2 : 4'd6;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== ~exp_r0 || bus.resp_result !== exp_res) begin
          errors++;
          $display("FAIL rr_resp %0d got v=%b id=%b res=%0d exp v=1 id=%b res=%0d", i - 2, bus.resp_valid, bus.resp_id, bus.resp_result, ~exp_r0, exp_res);
        end
      end else begin
        checks++;
        if (bus.resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL rr_no_resp %0d got %b exp 0", i, bus.resp_valid);
        end
      end
    end
  endtask

  task automatic test_req0_single();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd4; bus.req0_op = 3'b000;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL req0_ready got r0=%b r1=%b exp r0=1 r1=0", bus.req0_ready, bus.req1_ready);
    end
    checks++;
    if ({bus.alu_issue, bus.alu_a, bus.alu_b, bus.alu_op} !== {1'b1, 4'd3, 4'd4, 3'b000}) begin
      errors++;
      $display("FAIL req0_issue got %b/%0d/%0d/%b exp 1/3/4/000", bus.alu_issue, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || {bus.alu_issue, bus.alu_a, bus.alu_b, bus.alu_op} !== 12'h0) begin
      errors++;
      $display("FAIL req0_gap got resp_valid=%b alu=%h exp 0 and 0", bus.resp_valid, {bus.alu_issue, bus.alu_a, bus.alu_b, bus.alu_op});
    end
    @(negedge clk);
    checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags} !== {1'b1, 1'b0, 4'd7, 4'b0000}) begin
      errors++;
      $display("FAIL req0_resp got v=%b id=%b res=%0d flags=%b exp v=1 id=0 res=7 flags=0000", bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags);
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_result !== 4'd0) begin
      errors++;
      $display("FAIL req0_resp_end got v=%b res=%0d exp v=0 res=0", bus.resp_valid, bus.resp_result);
    end
  endtask

  task automatic test_req1_wrap();
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_a = 4'd8; bus.req1_b = 4'd8; bus.req1_op = 3'b000;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL req1_ready got r0=%b r1=%b exp r0=0 r1=1", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    // 8+8 = 16 wraps to 0: neg=0 zero=1 carry=1 over=1
    checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags} !== {1'b1, 1'b1, 4'd0, 4'b0111}) begin
      errors++;
      $display("FAIL req1_resp got v=%b id=%b res=%0d flags=%b exp v=1 id=1 res=0 flags=0111", bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd2; bus.req0_op = 3'b000;
    @(negedge clk);
    drive_idle();
    bus.req1_valid = 1'b1; bus.req1_a = 4'd5; bus.req1_b = 4'd1; bus.req1_op = 3'b000;
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_result !== 4'd3) begin
      errors++;
      $display("FAIL mid_pre_reset got v=%b res=%0d exp v=1 res=3", bus.resp_valid, bus.resp_result);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_result !== 4'd0) begin
      errors++;
      $display("FAIL mid_async_drop got v=%b res=%0d exp v=0 res=0", bus.resp_valid, bus.resp_result);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_resp cyc %0d got %b exp 0", i, bus.resp_valid);
      end
    end
    // Reset restored last_grant=1, so a tie goes to requester 0 again.
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_tie_after_reset got r0=%b r1=%b exp r0=1 r1=0", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL stats_reset got c0=%0d c1=%0d exp 0 0", grant_cnt0, grant_cnt1);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (grant_cnt0 !== 8'd200 || grant_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL stats_200 got c0=%0d c1=%0d exp 200 0", grant_cnt0, grant_cnt1);
    end
    repeat (100) @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (grant_cnt0 !== 8'd255 || grant_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL stats_sat got c0=%0d c1=%0d exp 255 0", grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_req0_single();
    test_req1_wrap();
    test_reset_midflight();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
